// File: rtl/nabp_projection_filter.sv
// Streaming FIR ramp filter: convolves each detector line with a programmable
// centred kernel (zero padded at both ends), one output per input sample.
module nabp_projection_filter #(
  parameter int kDataLength         = 8,
  parameter int kCoefLength         = 12,
  parameter int kCoefFracBits       = 10,
  parameter int kFilteredDataLength = 16,
  parameter int kTaps               = 9
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  coef_we,
  input  logic [$clog2(kTaps)-1:0]              coef_addr,
  input  logic signed [kCoefLength-1:0]         coef_val,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [kDataLength-1:0]                in_val,
  input  logic                                  in_sol,
  input  logic                                  in_eol,
  output logic                                  out_valid,
  output logic signed [kFilteredDataLength-1:0] out_val,
  output logic                                  out_sol,
  output logic                                  out_eol,
  output logic                                  busy,
  output logic                                  line_error
);

  localparam int C   = (kTaps - 1) / 2;
  localparam int PW  = kDataLength + 1 + kCoefLength;
  localparam int SW0 = PW + $clog2(kTaps) + 1;
  localparam int SW  = (SW0 > kFilteredDataLength) ? SW0 : kFilteredDataLength + 1;
  localparam int SCW = $clog2(C + 2);
  localparam int FCW = $clog2(C + 1);
  localparam int W   = kFilteredDataLength;
  localparam logic signed [SW-1:0] kRoundBias = SW'(1) <<< (kCoefFracBits - 1);

  if ((kTaps % 2) == 0 || kTaps < 3) begin : g_bad_taps
    $error("nabp_projection_filter: kTaps=%0d must be odd and >= 3", kTaps);
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                        r_state, w_state_next;
  logic                          r_ready;
  logic [kDataLength-1:0]        r_delay [kTaps];
  logic signed [kCoefLength-1:0] r_coef  [kTaps];
  logic signed [PW-1:0]          r_prod  [kTaps];
  logic [SCW-1:0]                r_s;
  logic [FCW-1:0]                r_f;
  logic                          r_issue, r_iss_sol, r_iss_eol;
  logic                          r_p_valid, r_p_sol, r_p_eol;
  logic                          r_out_valid, r_out_sol, r_out_eol, r_line_error;
  logic signed [W-1:0]           r_out_val;

  logic                          w_accept, w_shift, w_clear, w_abort, w_coef_wr, w_last_flush;
  logic [kDataLength-1:0]        w_din;
  logic [SCW-1:0]                w_s_base, w_s_next;
  logic [FCW-1:0]                w_f_next;
  logic signed [SW-1:0]          w_acc, w_rnd, w_sh;
  logic signed [W-1:0]           w_sat;

  assign w_accept = in_valid && r_ready;

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_abort      = 1'b0;
    w_coef_wr    = 1'b0;
    w_last_flush = 1'b0;
    w_din        = '0;
    w_s_base     = r_s;
    w_f_next     = r_f;
    case (r_state)
      S_IDLE: begin
        w_coef_wr = coef_we;
        if (w_accept && in_sol) begin
          w_shift      = 1'b1;
          w_clear      = 1'b1;
          w_din        = in_val;
          w_s_base     = '0;
          w_f_next     = '0;
          w_state_next = in_eol ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_shift = 1'b1;
          w_din   = in_val;
          // A fresh sol inside a line restarts the line from this sample.
          if (in_sol) begin
            w_abort  = 1'b1;
            w_clear  = 1'b1;
            w_s_base = '0;
          end
          if (in_eol) begin
            w_f_next     = '0;
            w_state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        w_shift = 1'b1;
        if (r_f == FCW'(C - 1)) begin
          w_last_flush = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_f_next = r_f + FCW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    w_s_next = (w_s_base < SCW'(C + 1)) ? w_s_base + SCW'(1) : SCW'(C + 1);
  end

  always_comb begin
    w_acc = '0;
    for (int unsigned k = 0; k < kTaps; k++) begin
      w_acc = w_acc + SW'(r_prod[k]);
    end
    w_rnd = w_acc + kRoundBias;
    w_sh  = w_rnd >>> kCoefFracBits;
    if (w_sh[SW-1:W-1] == '0 || w_sh[SW-1:W-1] == '1) begin
      w_sat = w_sh[W-1:0];
    end else begin
      w_sat = w_sh[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_delay      <= '{default: '0};
      r_coef       <= '{default: '0};
      r_prod       <= '{default: '0};
      r_s          <= '0;
      r_f          <= '0;
      r_issue      <= 1'b0;
      r_iss_sol    <= 1'b0;
      r_iss_eol    <= 1'b0;
      r_p_valid    <= 1'b0;
      r_p_sol      <= 1'b0;
      r_p_eol      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_val    <= '0;
      r_out_sol    <= 1'b0;
      r_out_eol    <= 1'b0;
      r_line_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ready      <= (w_state_next != S_FLUSH);
      r_line_error <= w_abort;
      if (w_coef_wr && int'(coef_addr) < kTaps) r_coef[coef_addr] <= coef_val;
      if (w_shift) begin
        r_delay[0] <= w_din;
        for (int unsigned k = 1; k < kTaps; k++) begin
          r_delay[k] <= w_clear ? '0 : r_delay[k-1];
        end
        r_s <= w_s_next;
        r_f <= w_f_next;
      end
      // Stage 0: window issue flags travel alongside the shift.
      r_issue   <= w_shift && (w_s_next == SCW'(C + 1));
      r_iss_sol <= w_shift && (w_s_base == SCW'(C));
      r_iss_eol <= w_last_flush;
      r_p_valid <= r_issue;
      r_p_sol   <= r_iss_sol;
      r_p_eol   <= r_iss_eol;
      for (int unsigned k = 0; k < kTaps; k++) begin
        r_prod[k] <= PW'(r_coef[k]) * PW'($signed({1'b0, r_delay[k]}));
      end
      r_out_valid <= r_p_valid;
      r_out_sol   <= r_p_valid && r_p_sol;
      r_out_eol   <= r_p_valid && r_p_eol;
      r_out_val   <= r_p_valid ? w_sat : '0;
    end
  end

  assign in_ready   = r_ready;
  assign out_valid  = r_out_valid;
  assign out_val    = r_out_val;
  assign out_sol    = r_out_sol;
  assign out_eol    = r_out_eol;
  assign line_error = r_line_error;
  assign busy       = (r_state != S_IDLE) || r_issue || r_p_valid;

endmodule

// File: tb/tb_nabp_projection_filter.sv
// Bench for nabp_projection_filter: random lines checked against a direct
// convolution model; a second narrow-output instance exercises saturation.
module tb_nabp_projection_filter;
  localparam int DL = 8, CL = 12, FB = 10, OW = 16, OW2 = 12, TAPS = 9, C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1, coef_we = 1'b0, in_valid = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
  logic [3:0]           coef_addr = '0;
  logic signed [CL-1:0] coef_val = '0;
  logic [DL-1:0]        in_val = '0;
  logic                 in_ready, out_valid, out_sol, out_eol, busy, line_error;
  logic signed [OW-1:0] out_val;
  logic                 in_ready_b, out_valid_b, out_sol_b, out_eol_b, busy_b, line_error_b;
  logic signed [OW2-1:0] out_val_b;

  nabp_projection_filter #(.kDataLength(DL), .kCoefLength(CL), .kCoefFracBits(FB),
    .kFilteredDataLength(OW), .kTaps(TAPS)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_val(coef_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_sol(in_sol), .in_eol(in_eol),
    .out_valid(out_valid), .out_val(out_val), .out_sol(out_sol), .out_eol(out_eol),
    .busy(busy), .line_error(line_error));

  nabp_projection_filter #(.kDataLength(DL), .kCoefLength(CL), .kCoefFracBits(FB),
    .kFilteredDataLength(OW2), .kTaps(TAPS)) dut_narrow (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_val(coef_val),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_val(in_val), .in_sol(in_sol), .in_eol(in_eol),
    .out_valid(out_valid_b), .out_val(out_val_b), .out_sol(out_sol_b), .out_eol(out_eol_b),
    .busy(busy_b), .line_error(line_error_b));

  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, n_lerr = 0;
  int cf [TAPS];
  int xl [256];
  int xn = 0;
  int acc_at [256];
  int q_val[$], q_cyc[$], qb_val[$];
  bit q_sol[$], q_eol[$];
  int e_val[$];
  bit e_sol[$], e_eol[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_val.push_back(int'(out_val)); q_sol.push_back(out_sol);
      q_eol.push_back(out_eol); q_cyc.push_back(cyc);
    end
    if (out_valid_b) qb_val.push_back(int'(out_val_b));
    if (line_error) n_lerr++;
  end

  // Direct convolution of the current line with zero padding outside it.
  function automatic int model_y(input int n, input int w);
    longint acc = 0;
    longint lim;
    for (int k = 0; k < TAPS; k++) begin
      int idx = n + C - k;
      if (idx >= 0 && idx < xn) acc += longint'(cf[k]) * longint'(xl[idx]);
    end
    acc = (acc + 512) >>> FB;
    lim = longint'(1) << (w - 1);
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return int'(acc);
  endfunction

  function automatic void expect_line(input int count, input bit with_eol);
    for (int n = 0; n < count; n++) begin
      e_val.push_back(model_y(n, OW));
      e_sol.push_back(n == 0);
      e_eol.push_back(with_eol && n == xn - 1);
    end
  endfunction

  function automatic void clear_q();
    q_val.delete(); q_sol.delete(); q_eol.delete(); q_cyc.delete(); qb_val.delete();
    e_val.delete(); e_sol.delete(); e_eol.delete();
  endfunction

  task automatic wr_coef(input int k, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(k); coef_val = CL'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic load_kernel(input int c [TAPS]);
    for (int k = 0; k < TAPS; k++) begin
      wr_coef(k, c[k]);
      cf[k] = c[k];
    end
  endtask

  task automatic send(input int v, input bit sol, input bit eol);
    int unsigned g = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!in_ready && g < 40) begin @(negedge clk); g++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1; in_val = DL'(v); in_sol = sol; in_eol = eol;
    @(posedge clk); #1;
    acc_cyc = cyc;
  endtask

  task automatic end_stim();
    @(negedge clk);
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0; coef_we = 1'b0;
  endtask

  task automatic push_line();
    for (int i = 0; i < xn; i++) begin
      send(xl[i], i == 0, i == xn - 1);
      acc_at[i] = acc_cyc;
    end
  endtask

  task automatic drain();
    int unsigned g = 0;
    @(negedge clk);
    while (busy && g < 200) begin @(negedge clk); g++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain busy=%0b want 0", busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_line(input int len);
    xn = len;
    for (int i = 0; i < len; i++) xl[i] = int'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, line_error, out_sol, out_eol} !== 6'b0 || out_val !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%0b ov=%0b busy=%0b lerr=%0b val=%0d want all 0",
               in_ready, out_valid, busy, line_error, out_val);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready in_ready=%0b want 1", in_ready); end
  endtask

  task automatic test_identity();
    int c [TAPS] = '{0, 0, 0, 0, 1024, 0, 0, 0, 0};
    load_kernel(c);
    clear_q();
    xn = 5;
    for (int i = 0; i < 5; i++) xl[i] = 10 * (i + 1);
    push_line(); end_stim(); drain();
    expect_line(xn, 1'b1);
    checks++;
    if (q_val.size() != e_val.size()) begin
      errors++; $display("FAIL ident_count got %0d want %0d", q_val.size(), e_val.size());
    end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      checks++;
      if (q_val[i] !== e_val[i] || q_val[i] !== 10 * (i + 1) || q_sol[i] !== e_sol[i] || q_eol[i] !== e_eol[i]) begin
        errors++; $display("FAIL ident[%0d] got %0d/%0b/%0b want %0d/%0b/%0b",
                           i, q_val[i], q_sol[i], q_eol[i], e_val[i], e_sol[i], e_eol[i]);
      end
    end
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] - acc_at[4] != 2) begin
      errors++; $display("FAIL ident_latency got %0d want 2", q_cyc.size() ? q_cyc[0] - acc_at[4] : -1);
    end
  endtask

  task automatic test_ramp();
    int c [TAPS] = '{0, -12, 0, -104, 256, -104, 0, -12, 0};
    load_kernel(c);
    for (int r = 0; r < 2; r++) begin
      clear_q();
      if (r == 0) begin xn = 3; xl[0] = 100; xl[1] = 100; xl[2] = 100; end
      else rand_line(11);
      push_line(); end_stim(); drain();
      expect_line(xn, 1'b1);
      checks++;
      if (q_val.size() != e_val.size()) begin
        errors++; $display("FAIL ramp_count got %0d want %0d", q_val.size(), e_val.size());
      end
      for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
        checks++;
        if (q_val[i] !== e_val[i] || q_sol[i] !== e_sol[i] || q_eol[i] !== e_eol[i]) begin
          errors++; $display("FAIL ramp[%0d] got %0d/%0b/%0b want %0d/%0b/%0b",
                             i, q_val[i], q_sol[i], q_eol[i], e_val[i], e_sol[i], e_eol[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c [TAPS];
    int prev_eol;
    for (int k = 0; k < TAPS; k++) c[k] = int'($urandom_range(0, 4095)) - 2048;
    load_kernel(c);
    clear_q();
    for (int l = 0; l < 6; l++) begin
      rand_line(int'($urandom_range(1, 12)));
      push_line();
      if (l > 0) begin
        checks++;
        if (acc_at[0] - prev_eol != C + 1) begin
          errors++; $display("FAIL b2b_gap line %0d got %0d want %0d", l, acc_at[0] - prev_eol, C + 1);
        end
      end
      prev_eol = acc_at[xn - 1];
      expect_line(xn, 1'b1);
    end
    end_stim(); drain();
    checks++;
    if (q_val.size() != e_val.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", q_val.size(), e_val.size());
    end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      checks++;
      if (q_val[i] !== e_val[i] || q_sol[i] !== e_sol[i] || q_eol[i] !== e_eol[i]) begin
        errors++; $display("FAIL b2b[%0d] got %0d/%0b/%0b want %0d/%0b/%0b",
                           i, q_val[i], q_sol[i], q_eol[i], e_val[i], e_sol[i], e_eol[i]);
      end
    end
  endtask

  task automatic test_len1();
    int c [TAPS] = '{0, 0, 0, 0, 1024, 0, 0, 0, 0};
    int lowc = 0;
    load_kernel(c);
    clear_q();
    send(64, 1'b1, 1'b1);
    end_stim();
    while (!in_ready && lowc < 20) begin lowc++; @(negedge clk); end
    checks++;
    if (lowc != C) begin errors++; $display("FAIL len1_ready_low got %0d want %0d", lowc, C); end
    drain();
    checks++;
    if (q_val.size() != 1 || q_val[0] !== 64 || q_sol[0] !== 1'b1 || q_eol[0] !== 1'b1) begin
      errors++; $display("FAIL len1_out got n=%0d v=%0d want n=1 v=64 sol=1 eol=1",
                         q_val.size(), q_val.size() ? q_val[0] : 0);
    end
  endtask

  task automatic test_abort();
    int c [TAPS];
    int lerr0, neol;
    for (int k = 0; k < TAPS; k++) c[k] = int'($urandom_range(0, 4095)) - 2048;
    load_kernel(c);
    clear_q();
    lerr0 = n_lerr;
    rand_line(7);
    for (int i = 0; i < xn; i++) send(xl[i], i == 0, 1'b0);
    expect_line(3, 1'b0);
    rand_line(4);
    push_line();
    expect_line(xn, 1'b1);
    end_stim(); drain();
    checks++;
    if (n_lerr - lerr0 != 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", n_lerr - lerr0); end
    neol = 0;
    foreach (q_eol[i]) neol += int'(q_eol[i]);
    checks++;
    if (neol != 1) begin errors++; $display("FAIL abort_eol_count got %0d want 1", neol); end
    checks++;
    if (q_val.size() != e_val.size()) begin
      errors++; $display("FAIL abort_count got %0d want %0d", q_val.size(), e_val.size());
    end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      checks++;
      if (q_val[i] !== e_val[i] || q_sol[i] !== e_sol[i] || q_eol[i] !== e_eol[i]) begin
        errors++; $display("FAIL abort[%0d] got %0d/%0b/%0b want %0d/%0b/%0b",
                           i, q_val[i], q_sol[i], q_eol[i], e_val[i], e_sol[i], e_eol[i]);
      end
    end
  endtask

  task automatic test_coef_busy();
    int c [TAPS] = '{0, 0, 0, 0, 1024, 0, 0, 0, 0};
    load_kernel(c);
    clear_q();
    rand_line(6);
    for (int i = 0; i < xn; i++) begin
      send(xl[i], i == 0, i == xn - 1);
      coef_we = 1'b1; coef_addr = 4'(i + 2); coef_val = CL'(int'($urandom_range(1, 2047)));
    end
    end_stim(); drain();
    clear_q();
    push_line(); end_stim(); drain();
    checks++;
    if (q_val.size() != xn) begin errors++; $display("FAIL cbusy_count got %0d want %0d", q_val.size(), xn); end
    for (int i = 0; i < xn && i < q_val.size(); i++) begin
      checks++;
      if (q_val[i] !== xl[i]) begin errors++; $display("FAIL cbusy[%0d] got %0d want %0d", i, q_val[i], xl[i]); end
    end
  endtask

  task automatic test_saturation();
    int c [TAPS];
    int want_b;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < TAPS; k++) c[k] = (p == 0) ? 2047 : -2048;
      want_b = (p == 0) ? 2047 : -2048;
      load_kernel(c);
      clear_q();
      xn = 9;
      for (int i = 0; i < xn; i++) xl[i] = 255;
      push_line(); end_stim(); drain();
      expect_line(xn, 1'b1);
      checks++;
      if (qb_val.size() != xn || q_val.size() != xn) begin
        errors++; $display("FAIL sat_count got %0d/%0d want %0d", q_val.size(), qb_val.size(), xn);
      end
      for (int i = 0; i < xn && i < qb_val.size() && i < q_val.size(); i++) begin
        checks++;
        if (qb_val[i] !== want_b || qb_val[i] !== model_y(i, OW2) || q_val[i] !== e_val[i]) begin
          errors++; $display("FAIL sat[%0d] got narrow=%0d wide=%0d want narrow=%0d wide=%0d",
                             i, qb_val[i], q_val[i], want_b, e_val[i]);
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    int c [TAPS];
    for (int k = 0; k < TAPS; k++) c[k] = int'($urandom_range(1, 2047));
    load_kernel(c);
    clear_q();
    rand_line(6);
    push_line(); end_stim();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rflush_in_flush in_ready=%0b want 0", in_ready); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rflush_cleared out_valid=%0b busy=%0b want 0/0", out_valid, busy);
    end
    reset = 1'b0;
    for (int k = 0; k < TAPS; k++) cf[k] = 0;
    repeat (2) @(negedge clk);
    clear_q();
    xn = 5;
    for (int i = 0; i < xn; i++) xl[i] = int'($urandom_range(1, 255));
    push_line(); end_stim(); drain();
    checks++;
    if (q_val.size() != xn) begin errors++; $display("FAIL rflush_count got %0d want %0d", q_val.size(), xn); end
    for (int i = 0; i < xn && i < q_val.size(); i++) begin
      checks++;
      if (q_val[i] !== model_y(i, OW)) begin
        errors++; $display("FAIL rflush_zero[%0d] got %0d want %0d", i, q_val[i], model_y(i, OW));
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ramp();
    test_back_to_back();
    test_len1();
    test_abort();
    test_coef_busy();
    test_saturation();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
